if_stage: RTL and testbench
===========================

// Module: if_stage
// PURPOSE
//  Instruction-fetch stage. Feeds the decode stage across the IF->ID valid/allow_in handshake as {pc, inst}.
//  Consumes branch redirects from ID (br_data) and exception redirects from WB (wb_ex/ex_entry).
//  Drives an SRAM-like instruction port (req/addr_ok/data_ok), with at most one request outstanding.
//  Discards wrong-path fetches, including requests already in flight.
// PARAMETERS
//  RESET_PC   32'h1c000000  first fetch address after reset
//  TO_ID_W    64            to_ID_data width, {pc[31:0], inst[31:0]}
//  BR_W       33            br_data width, {br_taken, br_target[31:0]}
// PORTS
//  clk                clk   in   1        clock, rising edge
//  reset              in    1        asynchronous, active-high
//  wb_ex              in    1        exception/ertn redirect from WB
//  ex_entry           in    32       redirect target when wb_ex=1
//  br_data            in    BR_W     {br_taken, br_target} from ID
//  ID_allow_in        in    1        ID can accept this cycle
//  IF_to_ID_valid     out   1        to_ID_data valid
//  to_ID_data         out   TO_ID_W  {pc, inst}
//  inst_sram_req      out   1        fetch request
//  inst_sram_wr       out   1        constant 0
//  inst_sram_size     out   2        constant 2'd2 (word)
//  inst_sram_wstrb    out   4        constant 4'h0
//  inst_sram_addr     out   32       fetch address (= fetch_pc)
//  inst_sram_wdata    out   32       constant 0
//  inst_sram_addr_ok  in    1        request accepted this cycle
//  inst_sram_data_ok  in    1        rdata valid this cycle
//  inst_sram_rdata    in    32       returned instruction
// BEHAVIOUR
//  Clock/reset: one clock; reset is asynchronous and active-high.
//  Reset values: state=REQ, fetch_pc=RESET_PC, cancel=0, IF_to_ID_valid=0, to_ID_data=0, inst_sram_req=0 while reset high.
//  redirect = wb_ex | br_taken; target = wb_ex ? ex_entry : br_target. wb_ex has priority.
//  Every redirect sets fetch_pc<=target, takes priority over all pc+4 updates, and kills any wrong-path instruction.
//  Outputs: inst_sram_req = (state==REQ); inst_sram_addr = fetch_pc; IF_to_ID_valid = (state==HOLD).
//  FSM REQ: req asserted. addr/req may change while addr_ok=0.
//   - addr_ok=1: req_pc<=fetch_pc, fetch_pc<=fetch_pc+4 (mod 2^32, no wrap check), ->WAIT.
//     If redirect in the same cycle: fetch_pc<=target, cancel<=1.
//   - addr_ok=0 with redirect: fetch_pc<=target, stay REQ, no cancel.
//  FSM WAIT: req=0.
//   - data_ok & ~cancel & ~redirect: to_ID_data<={req_pc, rdata}, ->HOLD.
//   - data_ok & (cancel|redirect): drop data, cancel<=0, ->REQ.
//   - ~data_ok & redirect: cancel<=1, stay WAIT.
//  FSM HOLD: inst buffered; held stable until handed off.
//   - redirect (any ID_allow_in): drop buffer, ->REQ.
//   - ID_allow_in & ~redirect: handoff, ->REQ.
//   - else stay HOLD.
//  Latency and throughput: data_ok cycle -> IF_to_ID_valid next cycle; minimum 3 cycles per instruction (REQ, WAIT, HOLD).
//  Simultaneous br_taken and handoff: the instruction is not delivered (ID also clears its valid on br_taken).
//  data_ok while in REQ or HOLD: protocol error, ignored.
//  Reset mid-request: state returns to REQ at RESET_PC. The memory model must be reset with the block.
// TESTING
//  T1 reset release, addr_ok/data_ok every cycle, ID_allow_in=1 -> addr 1c000000, 1c000004, ...;
//     {pc,inst} delivered in order, one per 3 cycles.
//  T2 ID_allow_in=0 for 5 cycles in HOLD -> IF_to_ID_valid held at 1, to_ID_data stable, no new req.
//     Release -> req for pc+4 next cycle.
//  T3 br_data={1,32'h1c000100} in WAIT, data_ok 2 cycles later -> that inst dropped;
//     next req addr=1c000100, first delivered pc=1c000100.
//  T4 wb_ex=1, ex_entry=1c008000, and br_taken in the same cycle as addr_ok -> cancel set, returned data dropped;
//     next addr=1c008000.
//  T5 br_taken in HOLD with ID_allow_in=1 -> buffered inst not delivered (valid low next cycle); req at target.
//  T6 reset asserted while in WAIT -> outputs at reset values immediately; after release, req at RESET_PC, cancel=0.

Source files
------------

// File: rtl/if_stage.sv
// Instruction-fetch stage: a REQ/WAIT/HOLD FSM drives a single-outstanding SRAM-like
// fetch port and buffers one {pc, inst} for the IF->ID handshake.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h1c000000,
    parameter int          TO_ID_W  = 64,
    parameter int          BR_W     = 33
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               wb_ex,
    input  logic [31:0]        ex_entry,
    input  logic [BR_W-1:0]    br_data,
    input  logic               ID_allow_in,
    output logic               IF_to_ID_valid,
    output logic [TO_ID_W-1:0] to_ID_data,
    output logic               inst_sram_req,
    output logic               inst_sram_wr,
    output logic [1:0]         inst_sram_size,
    output logic [3:0]         inst_sram_wstrb,
    output logic [31:0]        inst_sram_addr,
    output logic [31:0]        inst_sram_wdata,
    input  logic               inst_sram_addr_ok,
    input  logic               inst_sram_data_ok,
    input  logic [31:0]        inst_sram_rdata
);

    typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD} state_t;

    state_t             state, state_n;
    logic [31:0]        fetch_pc, fetch_pc_n;
    logic [31:0]        req_pc, req_pc_n;
    logic               cancel, cancel_n;
    logic [TO_ID_W-1:0] inst_buf, inst_buf_n;

    logic        br_taken;
    logic [31:0] br_target;
    logic        redirect;
    logic [31:0] target;

    assign br_taken  = br_data[BR_W-1];
    assign br_target = br_data[31:0];
    assign redirect  = wb_ex | br_taken;
    assign target    = wb_ex ? ex_entry : br_target;

    // req is gated by reset so the port is quiet for the whole reset pulse
    assign inst_sram_req   = (state == S_REQ) & ~reset;
    assign inst_sram_addr  = fetch_pc;
    assign inst_sram_wr    = 1'b0;
    assign inst_sram_size  = 2'd2;
    assign inst_sram_wstrb = 4'h0;
    assign inst_sram_wdata = 32'h0;
    assign IF_to_ID_valid  = (state == S_HOLD);
    assign to_ID_data      = inst_buf;

    always_comb begin
        state_n    = state;
        fetch_pc_n = fetch_pc;
        req_pc_n   = req_pc;
        cancel_n   = cancel;
        inst_buf_n = inst_buf;
        case (state)
            S_REQ: begin
                if (inst_sram_addr_ok) begin
                    req_pc_n   = fetch_pc;
                    fetch_pc_n = fetch_pc + 32'd4;
                    state_n    = S_WAIT;
                    // request already accepted: its data must be discarded on return
                    if (redirect) begin
                        fetch_pc_n = target;
                        cancel_n   = 1'b1;
                    end
                end else if (redirect) begin
                    fetch_pc_n = target;
                end
            end
            S_WAIT: begin
                if (redirect)
                    fetch_pc_n = target;
                if (inst_sram_data_ok) begin
                    if (cancel | redirect) begin
                        cancel_n = 1'b0;
                        state_n  = S_REQ;
                    end else begin
                        inst_buf_n = TO_ID_W'({req_pc, inst_sram_rdata});
                        state_n    = S_HOLD;
                    end
                end else if (redirect) begin
                    cancel_n = 1'b1;
                end
            end
            S_HOLD: begin
                if (redirect) begin
                    fetch_pc_n = target;
                    state_n    = S_REQ;
                end else if (ID_allow_in) begin
                    state_n = S_REQ;
                end
            end
            default: state_n = S_REQ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_REQ;
            fetch_pc <= RESET_PC;
            req_pc   <= RESET_PC;
            cancel   <= 1'b0;
            inst_buf <= '0;
        end else begin
            state    <= state_n;
            fetch_pc <= fetch_pc_n;
            req_pc   <= req_pc_n;
            cancel   <= cancel_n;
            inst_buf <= inst_buf_n;
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// Randomized bench for if_stage: memory responder + redirect driver feed a queue of
// expected fetch PCs; a monitor pops it on every IF->ID handoff.
module tb_if_stage;

    localparam logic [31:0] RESET_PC = 32'h1c000000;

    logic        clk = 1'b0;
    logic        reset;
    logic        wb_ex;
    logic [31:0] ex_entry;
    logic [32:0] br_data;
    logic        ID_allow_in;
    logic        IF_to_ID_valid;
    logic [63:0] to_ID_data;
    logic        inst_sram_req, inst_sram_wr;
    logic [1:0]  inst_sram_size;
    logic [3:0]  inst_sram_wstrb;
    logic [31:0] inst_sram_addr, inst_sram_wdata;
    logic        inst_sram_addr_ok, inst_sram_data_ok;
    logic [31:0] inst_sram_rdata;

    if_stage #(.RESET_PC(RESET_PC), .TO_ID_W(64), .BR_W(33)) dut (
        .clk(clk), .reset(reset), .wb_ex(wb_ex), .ex_entry(ex_entry), .br_data(br_data),
        .ID_allow_in(ID_allow_in), .IF_to_ID_valid(IF_to_ID_valid), .to_ID_data(to_ID_data),
        .inst_sram_req(inst_sram_req), .inst_sram_wr(inst_sram_wr),
        .inst_sram_size(inst_sram_size), .inst_sram_wstrb(inst_sram_wstrb),
        .inst_sram_addr(inst_sram_addr), .inst_sram_wdata(inst_sram_wdata),
        .inst_sram_addr_ok(inst_sram_addr_ok), .inst_sram_data_ok(inst_sram_data_ok),
        .inst_sram_rdata(inst_sram_rdata)
    );

    always #5 clk = ~clk;

    int          n_tests = 0, n_fail = 0;
    logic [31:0] exp_q[$];
    logic [31:0] exp_next;
    bit          fast, in_reset, post_rst;
    bit          outstanding;
    logic [31:0] out_addr;

    function automatic logic [31:0] mem_f(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5a5a3c3c;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic restart_stream(input logic [31:0] pc);
        exp_q.delete();
        exp_next = pc;
    endtask

    // one cycle of stimulus, entered and left at a falling edge
    task automatic cycle(input bit rnd);
        bit busy;
        int r;
        busy = outstanding;
        inst_sram_data_ok = 1'b0;
        inst_sram_addr_ok = 1'b0;
        inst_sram_rdata   = $urandom;
        wb_ex    = 1'b0;
        ex_entry = $urandom;
        br_data  = {1'b0, 32'($urandom)};
        if (outstanding && (fast || $urandom_range(0, 2) == 0)) begin
            inst_sram_data_ok = 1'b1;
            inst_sram_rdata   = mem_f(out_addr);
            outstanding       = 1'b0;
        end
        if (inst_sram_req) begin
            chk("one_outstanding", 64'(busy), 64'd0);
            inst_sram_addr_ok = fast || ($urandom_range(0, 1) == 1);
            if (inst_sram_addr_ok) begin
                outstanding = 1'b1;
                out_addr    = inst_sram_addr;
            end
        end
        ID_allow_in = fast || ($urandom_range(0, 9) < 7);
        if (rnd) begin
            r = $urandom_range(0, 99);
            if (r < 4) begin
                wb_ex    = 1'b1;
                ex_entry = 32'h1c008000 + (32'($urandom_range(0, 63)) << 2);
            end
            if (r < 2 || (r >= 10 && r < 20))
                br_data = {1'b1, 32'h1c000000 + (32'($urandom_range(0, 255)) << 2)};
        end
        if (wb_ex) restart_stream(ex_entry);
        else if (br_data[32]) restart_stream(br_data[31:0]);
        while (exp_q.size() < 8) begin
            exp_q.push_back(exp_next);
            exp_next += 32'd4;
        end
        @(negedge clk);
    endtask

    // monitor
    initial begin
        bit          prev_hold, prev_leave, prev_fast_ho;
        logic [63:0] prev_data;
        int          cyc, last_ho, idle;
        logic [31:0] e;
        bit          redir, dog_fired;
        prev_hold = 0; prev_leave = 0; prev_fast_ho = 0; prev_data = '0;
        cyc = 0; last_ho = 0; idle = 0; dog_fired = 0;
        forever begin
            @(negedge clk);
            #1;
            cyc++;
            if (in_reset) begin
                prev_hold = 0; prev_leave = 0; prev_fast_ho = 0; idle = 0;
                continue;
            end
            redir = wb_ex | br_data[32];
            chk("const_port", {inst_sram_wr, inst_sram_size, inst_sram_wstrb, inst_sram_wdata},
                {1'b0, 2'd2, 4'h0, 32'h0});
            if (post_rst) begin
                chk("post_rst_req", 64'(inst_sram_req), 64'd1);
                chk("post_rst_addr", 64'(inst_sram_addr), 64'(RESET_PC));
                post_rst = 0;
            end
            if (prev_hold) begin
                chk("hold_valid", 64'(IF_to_ID_valid), 64'd1);
                chk("hold_data", to_ID_data, prev_data);
            end
            if (prev_leave)
                chk("leave_hold", {63'd0, IF_to_ID_valid, inst_sram_req}, 64'b01);
            if (IF_to_ID_valid && ID_allow_in && !redir) begin
                idle = 0;
                if (exp_q.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL deliver: unexpected pc %h, expected none", to_ID_data[63:32]);
                end else begin
                    e = exp_q.pop_front();
                    chk("deliver_pc", 64'(to_ID_data[63:32]), 64'(e));
                    chk("deliver_inst", 64'(to_ID_data[31:0]), 64'(mem_f(e)));
                end
                if (fast && prev_fast_ho) chk("throughput_gap", 64'(cyc - last_ho), 64'd3);
                prev_fast_ho = fast;
                last_ho = cyc;
            end else if (redir) begin
                idle = 0;
            end else begin
                idle++;
            end
            if (idle > 100 && !dog_fired) begin
                n_tests++; n_fail++; dog_fired = 1;
                $display("FAIL watchdog: %0d idle cycles, limit 100", idle);
            end
            prev_hold  = IF_to_ID_valid && !ID_allow_in && !redir;
            prev_leave = IF_to_ID_valid && (ID_allow_in || redir);
            prev_data  = to_ID_data;
        end
    end

    // driver and memory responder
    initial begin
        reset = 1; in_reset = 1; post_rst = 0; fast = 0; outstanding = 0; out_addr = '0;
        wb_ex = 0; ex_entry = '0; br_data = '0; ID_allow_in = 0;
        inst_sram_addr_ok = 0; inst_sram_data_ok = 0; inst_sram_rdata = '0;
        restart_stream(RESET_PC);
        repeat (3) @(negedge clk);
        chk("rst_valid", 64'(IF_to_ID_valid), 64'd0);
        chk("rst_req", 64'(inst_sram_req), 64'd0);
        chk("rst_data", to_ID_data, 64'd0);
        chk("rst_addr", 64'(inst_sram_addr), 64'(RESET_PC));
        reset = 0; in_reset = 0; post_rst = 1; fast = 1;
        repeat (30) cycle(0);
        fast = 0;
        repeat (1500) cycle(1);
        for (int i = 0; i < 50; i++) begin
            if (outstanding && !inst_sram_req) break;
            cycle(0);
        end
        reset = 1; in_reset = 1;
        #1;
        chk("midrst_req", 64'(inst_sram_req), 64'd0);
        chk("midrst_valid", 64'(IF_to_ID_valid), 64'd0);
        chk("midrst_data", to_ID_data, 64'd0);
        chk("midrst_addr", 64'(inst_sram_addr), 64'(RESET_PC));
        outstanding = 0; inst_sram_addr_ok = 0; inst_sram_data_ok = 0;
        wb_ex = 0; br_data = '0;
        restart_stream(RESET_PC);
        repeat (2) @(negedge clk);
        reset = 0; in_reset = 0; post_rst = 1;
        repeat (800) cycle(1);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
